// File: rtl/uc_multiciclo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uc_multiciclo                                        |
// | Description : Multi-cycle control unit. Sequences FETCH, DECODE    |
// |               and EXEC per instruction, handshakes with a          |
// |               variable-latency instruction memory, drives the      |
// |               datapath strobes, counts retired instructions and    |
// |               halts on an illegal opcode or a fetch timeout.       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module uc_multiciclo #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int TIMEOUT_W      = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ready,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_we,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic [1:0]       state,
  output logic             halted,
  output logic             fault_illegal,
  output logic             fault_timeout,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  // A zero TIMEOUT_CYCLES disables the timeout; the compare value is then unused.
  localparam bit                 c_timeout_en = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] c_wait_last =
    TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t               r_state;
  state_t               w_state_next;
  logic [TIMEOUT_W-1:0] r_wait;
  logic                 r_fault_illegal;
  logic                 r_fault_timeout;
  logic [CNT_W-1:0]     r_retired;

  logic w_wait_inc, w_wait_clr, w_set_timeout, w_set_illegal, w_retire;
  logic w_imem_req, w_ir_load, w_pc_we, w_s_inc, w_s_inm, w_we3, w_wez;
  logic [2:0] w_op_alu;

  // Opcode classes
  logic w_is_alu, w_is_li, w_is_j, w_is_jz, w_is_jnz, w_legal;
  assign w_is_alu = opcode[5];
  assign w_is_li  = (opcode[5:2] == 4'b0000);
  assign w_is_j   = (opcode == 6'b000100);
  assign w_is_jz  = (opcode == 6'b000101);
  assign w_is_jnz = (opcode == 6'b000110);
  assign w_legal  = w_is_alu | w_is_li | w_is_j | w_is_jz | w_is_jnz;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  // Next-state selection and raw (ungated) strobes
  always_comb begin
    w_state_next  = r_state;
    w_wait_inc    = 1'b0;
    w_wait_clr    = 1'b0;
    w_set_timeout = 1'b0;
    w_set_illegal = 1'b0;
    w_retire      = 1'b0;
    w_imem_req    = 1'b0;
    w_ir_load     = 1'b0;
    w_pc_we       = 1'b0;
    w_s_inc       = 1'b0;
    w_s_inm       = 1'b0;
    w_we3         = 1'b0;
    w_wez         = 1'b0;
    w_op_alu      = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_imem_req = run;
        if (run) begin
          if (imem_ready) begin
            w_ir_load    = 1'b1;
            w_wait_clr   = 1'b1;
            w_state_next = S_DECODE;
          end else if (c_timeout_en && (r_wait == c_wait_last)) begin
            w_set_timeout = 1'b1;
            w_state_next  = S_HALT;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_state_next = S_EXEC;
        end else begin
          w_set_illegal = 1'b1;
          w_state_next  = S_HALT;
        end
      end
      S_EXEC: begin
        w_pc_we      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
        if (w_is_alu) begin
          w_op_alu = opcode[4:2];
          w_we3    = 1'b1;
          w_wez    = 1'b1;
          w_s_inc  = 1'b1;
        end else if (w_is_li) begin
          w_s_inm = 1'b1;
          w_we3   = 1'b1;
          w_s_inc = 1'b1;
        end else if (w_is_jz) begin
          w_s_inc = ~z;
        end else if (w_is_jnz) begin
          w_s_inc = z;
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  // Wait counter, sticky faults and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait          <= '0;
      r_fault_illegal <= 1'b0;
      r_fault_timeout <= 1'b0;
      r_retired       <= '0;
    end else begin
      if (w_wait_clr)      r_wait <= '0;
      else if (w_wait_inc) r_wait <= r_wait + TIMEOUT_W'(1);
      if (w_set_illegal) r_fault_illegal <= 1'b1;
      if (w_set_timeout) r_fault_timeout <= 1'b1;
      if (w_retire)      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Reset masks every strobe so nothing is written while it is held
  assign imem_req      = w_imem_req & ~reset;
  assign ir_load       = w_ir_load  & ~reset;
  assign pc_we         = w_pc_we    & ~reset;
  assign s_inc         = w_s_inc    & ~reset;
  assign s_inm         = w_s_inm    & ~reset;
  assign we3           = w_we3      & ~reset;
  assign wez           = w_wez      & ~reset;
  assign op_alu        = reset ? 3'b000 : w_op_alu;
  assign state         = r_state;
  assign halted        = (r_state == S_HALT);
  assign fault_illegal = r_fault_illegal;
  assign fault_timeout = r_fault_timeout;
  assign retired       = r_retired;

endmodule
`default_nettype wire
